// File: rtl/rf_wb_arbiter_if.sv
// Request side of the register-file write-back arbiter: two valid/ready write producers.
// The master modport is the producer side and the slave modport is the arbiter side.
interface rf_wb_arbiter_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
);
  logic          a_valid;
  logic [AW-1:0] a_reg;
  logic [DW-1:0] a_data;
  logic          a_ready;
  logic          b_valid;
  logic [AW-1:0] b_reg;
  logic [DW-1:0] b_data;
  logic          b_ready;

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the register-file write port between the ALU (A) and MEM (B) paths.
// It registers one write per cycle, drops writes to r0, and forwards the in-flight write to reads.
module rf_wb_arbiter #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5,
  parameter int unsigned CW = 8
) (
  input  logic              clk,
  input  logic              rst,
  rf_wb_arbiter_if.slave    req,
  input  logic              stall_i,
  output logic [1:0]        reg_write_o,
  output logic [AW-1:0]     write_reg_o,
  output logic [DW-1:0]     write_data_o,
  input  logic [AW-1:0]     rd1_addr_i,
  input  logic [DW-1:0]     rf_data1_i,
  output logic [DW-1:0]     rd1_data_o,
  input  logic [AW-1:0]     rd2_addr_i,
  input  logic [DW-1:0]     rf_data2_i,
  output logic [DW-1:0]     rd2_data_o,
  output logic [CW-1:0]     drop_cnt_o
);

  logic [1:0]    reg_write_q;
  logic [AW-1:0] write_reg_q;
  logic [DW-1:0] write_data_q;
  logic [CW-1:0] drop_q;
  logic          ptr_q;  // 0: A has priority, 1: B has priority

  logic          grant_a;
  logic          grant_b;
  logic          xfer;
  logic [AW-1:0] sel_reg;
  logic [DW-1:0] sel_data;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst && !stall_i) begin
      if (req.a_valid && req.b_valid) begin
        grant_a = ~ptr_q;
        grant_b = ptr_q;
      end else begin
        grant_a = req.a_valid;
        grant_b = req.b_valid;
      end
    end
  end

  assign req.a_ready = grant_a;
  assign req.b_ready = grant_b;
  assign xfer        = grant_a | grant_b;
  assign sel_reg     = grant_a ? req.a_reg  : req.b_reg;
  assign sel_data    = grant_a ? req.a_data : req.b_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q  <= 2'b00;
      write_reg_q  <= '0;
      write_data_q <= '0;
      drop_q       <= '0;
      ptr_q        <= 1'b0;
    end else begin
      reg_write_q <= 2'b00;
      if (xfer) begin
        ptr_q <= grant_a;
        if (sel_reg != '0) begin
          reg_write_q  <= 2'b01;
          write_reg_q  <= sel_reg;
          write_data_q <= sel_data;
        end else if (drop_q != {CW{1'b1}}) begin
          drop_q <= drop_q + CW'(1);
        end
      end
    end
  end

  assign reg_write_o  = reg_write_q;
  assign write_reg_o  = write_reg_q;
  assign write_data_o = write_data_q;
  assign drop_cnt_o   = drop_q;

  // Bypass the registered write so a read in its commit cycle sees the new value.
  always_comb begin
    rd1_data_o = rf_data1_i;
    if (rd1_addr_i == '0) begin
      rd1_data_o = '0;
    end else if (reg_write_q == 2'b01 && write_reg_q == rd1_addr_i) begin
      rd1_data_o = write_data_q;
    end
  end

  always_comb begin
    rd2_data_o = rf_data2_i;
    if (rd2_addr_i == '0) begin
      rd2_data_o = '0;
    end else if (reg_write_q == 2'b01 && write_reg_q == rd2_addr_i) begin
      rd2_data_o = write_data_q;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with a register-file model and an expected-write scoreboard.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [1:0]  reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  rd1_addr;
  logic [4:0]  rd2_addr;
  logic [31:0] rf_data1;
  logic [31:0] rf_data2;
  logic [31:0] rd1_data;
  logic [31:0] rd2_data;
  logic [7:0]  drop_cnt;
  logic [31:0] rf [32];

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        we;
    logic [4:0]  r;
    logic [31:0] d;
  } exp_t;

  exp_t exp_q[$];

  rf_wb_arbiter_if #(.DW(32), .AW(5)) bus ();

  rf_wb_arbiter #(.DW(32), .AW(5), .CW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (bus),
    .stall_i      (stall),
    .reg_write_o  (reg_write),
    .write_reg_o  (write_reg),
    .write_data_o (write_data),
    .rd1_addr_i   (rd1_addr),
    .rf_data1_i   (rf_data1),
    .rd1_data_o   (rd1_data),
    .rd2_addr_i   (rd2_addr),
    .rf_data2_i   (rf_data2),
    .rd2_data_o   (rd2_data),
    .drop_cnt_o   (drop_cnt)
  );

  always #5 clk = ~clk;

  // Register-file model; r0 holds junk so read-port zeroing is observable.
  always @(posedge clk) begin
    if (reg_write === 2'b01) rf[write_reg] <= write_data;
  end
  assign rf_data1 = rf[rd1_addr];
  assign rf_data2 = rf[rd2_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive requests, check readies, then check the registered write after the edge.
  task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic bv, input logic [4:0] br, input logic [31:0] bd,
                      input logic st, input logic ea, input logic eb);
    exp_t e;
    bus.a_valid = av;
    bus.a_reg   = ar;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_reg   = br;
    bus.b_data  = bd;
    stall       = st;
    #1;
    chk("a_ready", {31'b0, bus.a_ready}, {31'b0, ea});
    chk("b_ready", {31'b0, bus.b_ready}, {31'b0, eb});
    e.we = 1'b0;
    e.r  = 5'd0;
    e.d  = 32'd0;
    if (ea && ar != 5'd0) begin
      e.we = 1'b1; e.r = ar; e.d = ad;
    end else if (eb && br != 5'd0) begin
      e.we = 1'b1; e.r = br; e.d = bd;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    chk("sb_depth", exp_q.size(), 32'd1);
    e = exp_q.pop_front();
    chk("reg_write", {30'b0, reg_write}, e.we ? 32'd1 : 32'd0);
    if (e.we) begin
      chk("write_reg", {27'b0, write_reg}, {27'b0, e.r});
      chk("write_data", write_data, e.d);
    end
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    rf[0] <= 32'hBAD0_BAD0;
    rst = 1'b1;
    stall = 1'b0;
    rd1_addr = 5'd0;
    rd2_addr = 5'd0;
    bus.a_valid = 1'b1; bus.a_reg = 5'd1; bus.a_data = 32'd1;
    bus.b_valid = 1'b1; bus.b_reg = 5'd2; bus.b_data = 32'd2;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_reg_write", {30'b0, reg_write}, 32'd0);
    chk("rst_write_reg", {27'b0, write_reg}, 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_drop_cnt", {24'b0, drop_cnt}, 32'd0);
    chk("rst_a_ready", {31'b0, bus.a_ready}, 32'd0);
    chk("rst_b_ready", {31'b0, bus.b_ready}, 32'd0);
    rst = 1'b0;

    // Contention: A,B,A,B from the reset pointer.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'd1, 32'd1, 1'b1, 5'd2, 32'd2, 1'b0, (i % 2) == 0, (i % 2) == 1);
    end
    idle();
    chk("rf_r1", rf[1], 32'd1);
    chk("rf_r2", rf[2], 32'd2);

    // Single write from A.
    step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    idle();
    rd2_addr = 5'd5;
    #1;
    chk("rf_r5", rf[5], 32'hDEAD_BEEF);
    chk("rd2_r5", rd2_data, 32'hDEAD_BEEF);

    // Forwarding of B's write to r7.
    rd1_addr = 5'd7;
    rd2_addr = 5'd0;
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234, 1'b0, 1'b0, 1'b1);
    chk("rf_data1_old", rf_data1, 32'd0);
    chk("fwd_rd1", rd1_data, 32'h1234);
    chk("fwd_rd2_zero", rd2_data, 32'd0);
    idle();
    chk("rd1_after", rd1_data, 32'h1234);
    chk("rf_data1_after", rf_data1, 32'h1234);

    // r0 writes are dropped and the counter saturates.
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 5'd0, i, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
      if (i == 9) chk("drop_cnt_10", {24'b0, drop_cnt}, 32'd10);
    end
    chk("drop_cnt_sat", {24'b0, drop_cnt}, 32'd255);
    chk("rf_r0_untouched", rf[0], 32'hBAD0_BAD0);

    // Put the pointer back on A, then stall with both valid.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b1, 1'b0, 1'b0);
    end
    step(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b0, 1'b1, 1'b0);

    // Reset while the A write to r3 is in flight.
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_reg_write", {30'b0, reg_write}, 32'd0);
    chk("midrst_drop_cnt", {24'b0, drop_cnt}, 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_rf_r3", rf[3], 32'd0);
    chk("rf_r9", rf[9], 32'h99);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Write-back arbiter and sequencer for the 32x32 register file's single write port. Two producers, the ALU result path (requester A) and the load/memory result path (requester B), compete for the port through valid/ready handshakes. Grants are round-robin, and each accepted write is issued to the register file through a registered stage. Writes to r0 are filtered out. The block also forwards the in-flight write onto both read ports so consumers never see a stale value.

Parameters:
DW, 32, data width of the write and read data paths
AW, 5, register address width (2^AW registers)
CW, 8, width of the saturating r0-drop counter

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
a_valid  in  1  requester A (ALU) has a write pending
a_reg  in  AW  requester A destination register
a_data  in  DW  requester A write data
a_ready  out  1  requester A write accepted this cycle
b_valid  in  1  requester B (MEM) has a write pending
b_reg  in  AW  requester B destination register
b_data  in  DW  requester B write data
b_ready  out  1  requester B write accepted this cycle
stall  in  1  suppresses all grants while high
RegWrite  out  2  register-file write enable; 2'b01 = write, 2'b00 = idle
WriteReg  out  AW  register-file write address
WriteData  out  DW  register-file write data
rd1_addr  in  AW  read port 1 address (same value driven to the RF Read1)
rf_data1  in  DW  raw RF Data1
rd1_data  out  DW  forwarded read data, port 1
rd2_addr  in  AW  read port 2 address
rf_data2  in  DW  raw RF Data2
rd2_data  out  DW  forwarded read data, port 2
drop_cnt  out  CW  count of accepted writes targeting r0, saturating

Behaviour:
- Reset (async, rst=1):
  - RegWrite=2'b00, WriteReg=0, WriteData=0.
  - drop_cnt=0.
  - Priority pointer points to A.
  - a_ready and b_ready are 0 while rst is high.
- Arbitration is combinational in cycle N:
  - stall=1 → a_ready=b_ready=0.
  - Else, only one requester valid → that requester is granted.
  - Else, both valid → the pointer's requester is granted.
  - Else → no grant.
  - At most one ready is high per cycle. ready never depends on ready.
- Handshake: a transfer occurs when valid && ready at the rising edge. A requester must hold valid/reg/data stable until accepted. An un-granted requester simply waits; there is no internal queue.
- Pointer update: after a granted transfer, the pointer moves to the non-granted requester. With no transfer, the pointer is unchanged. A single valid requester may therefore be granted on consecutive cycles.
- Output stage, transfer at edge N:
  - reg != 0: at edge N the block registers RegWrite=2'b01, WriteReg=reg, WriteData=data. These are visible during cycle N+1, and the RF commits at edge N+1. Accept-to-commit latency is 1 cycle.
  - reg == 0: RegWrite=2'b00 is registered, nothing reaches the RF, and drop_cnt increments, holding at 2^CW-1.
  - No transfer at edge N: RegWrite=2'b00. WriteReg and WriteData hold their previous values.
- Throughput: one write per cycle sustained. Back-to-back writes to the same register commit in grant order.
- Forwarding (combinational), for each port k:
  - rdk_addr==0 → rdk_data=0.
  - Else RegWrite==2'b01 && WriteReg==rdk_addr → rdk_data=WriteData.
  - Else → rdk_data=rf_dataK.
- Stall: stall asserted in the cycle after a grant does not cancel that grant; the registered write still issues.
- Reset mid-operation: an in-flight registered write is discarded (RegWrite cleared immediately). The requester must re-present it after reset.

Test Plan:
- Reset, then check outputs. Expect RegWrite=0, WriteReg=0, WriteData=0, drop_cnt=0, a_ready=b_ready=0 while rst=1.
- Single write. A writes r5=0xDEADBEEF at edge N. Expect a_ready=1 in cycle N; RegWrite=01, WriteReg=5, WriteData=0xDEADBEEF in cycle N+1; RF r5 reads 0xDEADBEEF after edge N+1.
- Contention. A and B both valid continuously for 4 cycles (A: r1=1 / B: r2=2, re-presented after each accept). Expect grants A,B,A,B and RF commits alternating r1/r2, one per cycle.
- Forwarding. Hold rd1_addr=7 and rd2_addr=0 while B writes r7=0x1234. In the cycle RegWrite=01, expect rd1_data=0x1234 even though rf_data1 is old, and rd2_data=0. The cycle after, expect rd1_data=rf_data1=0x1234.
- r0 filter and saturation. A writes r0 260 times with CW=8. Expect RegWrite never 01, a_ready=1 each time, drop_cnt ends at 255.
- Stall and reset mid-flight:
  - stall=1 with both valid for 3 cycles → no ready, RegWrite=00.
  - Release stall → A is granted first.
  - Assert rst in the cycle after that grant → RegWrite drops to 00 immediately and the RF is unchanged.
